ledr_channel_receiver: RTL and testbench

//  Clocked receiver (sink end) for a 2-phase LEDR (level-encoded dual-rail) bit channel.

---
 rtl/ledr_channel_receiver.sv | 127 ++++++++++++
 tb/tb_ledr_channel_receiver.sv | 201 ++++++++++++++++++++
 2 files changed

// File: rtl/ledr_channel_receiver.sv
// LEDR 2-phase bit-channel sink: synchronizes d/r, acks each token,
// and packs WIDTH bits LSB-first into a valid/ready word register.
module ledr_channel_receiver #(
  parameter  int WIDTH       = 8,
  parameter  int SYNC_STAGES = 2,
  localparam int CW          = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ledr_d,
  input  logic             ledr_r,
  output logic             ledr_a,
  output logic [WIDTH-1:0] word,
  output logic             word_valid,
  input  logic             word_ready,
  output logic [CW-1:0]    bit_count,
  output logic             proto_err
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]             r_rst_q;
  logic                   w_rst_n;
  logic [SYNC_STAGES-1:0] r_d_sync;
  logic [SYNC_STAGES-1:0] r_r_sync;
  logic                   r_d_p;
  logic                   r_r_p;
  logic                   r_ack;
  logic [WIDTH-2:0]       r_shift;
  logic [CW-1:0]          r_cnt;
  logic [WIDTH-1:0]       r_word;
  logic                   r_valid;
  logic                   r_err;

  logic                   w_d_s;
  logic                   w_r_s;
  logic                   w_dbl;
  logic                   w_pend;
  logic                   w_last;
  logic                   w_stall;
  logic                   w_acc;
  logic                   w_take;
  logic [WIDTH-2:0]       w_shift_nxt;

  // Reset asserts immediately but releases on a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rst_q <= 2'b00;
    end else begin
      r_rst_q <= {r_rst_q[0], 1'b1};
    end
  end

  assign w_rst_n = r_rst_q[1];

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_d_sync <= '0;
      r_r_sync <= '0;
      r_d_p    <= 1'b0;
      r_r_p    <= 1'b0;
    end else begin
      r_d_sync <= {r_d_sync[SYNC_STAGES-2:0], ledr_d};
      r_r_sync <= {r_r_sync[SYNC_STAGES-2:0], ledr_r};
      r_d_p    <= w_d_s;
      r_r_p    <= w_r_s;
    end
  end

  assign w_d_s = r_d_sync[SYNC_STAGES-1];
  assign w_r_s = r_r_sync[SYNC_STAGES-1];

  always_comb begin
    w_dbl   = (w_d_s != r_d_p) && (w_r_s != r_r_p);
    w_pend  = ((w_d_s ^ w_r_s) != r_ack) && !w_dbl;
    w_last  = (r_cnt == LAST);
    w_stall = w_last && r_valid && !word_ready;
    w_acc   = w_pend && !w_stall;
    w_take  = r_valid && word_ready;
  end

  always_comb begin
    w_shift_nxt = r_shift;
    for (int i = 0; i < WIDTH - 1; i++) begin
      if (r_cnt == CW'(i)) begin
        w_shift_nxt[i] = w_d_s;
      end
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_ack   <= 1'b0;
      r_shift <= '0;
      r_cnt   <= '0;
      r_word  <= '0;
      r_valid <= 1'b0;
    end else if (w_acc) begin
      r_ack <= ~r_ack;
      if (w_last) begin
        r_word  <= {w_d_s, r_shift};
        r_valid <= 1'b1;
        r_cnt   <= '0;
      end else begin
        r_shift <= w_shift_nxt;
        r_cnt   <= r_cnt + 1'b1;
      end
    end else if (w_take) begin
      r_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_err <= 1'b0;
    end else if (w_dbl) begin
      r_err <= 1'b1;
    end
  end

  assign ledr_a     = r_ack;
  assign word       = r_word;
  assign word_valid = r_valid;
  assign bit_count  = r_cnt;
  assign proto_err  = r_err;

endmodule

// File: tb/tb_ledr_channel_receiver.sv
// Directed bench for ledr_channel_receiver: an LEDR source model
// that waits on ledr_a, with hand-computed words and latencies.
module tb_ledr_channel_receiver;

  localparam int W  = 8;
  localparam int SS = 2;

  logic       clk;
  logic       rst_n;
  logic       src_d;
  logic       src_r;
  logic       ledr_a;
  logic [7:0] word;
  logic       word_valid;
  logic       word_ready;
  logic [3:0] bit_count;
  logic       proto_err;

  int n_tot  = 0;
  int n_pass = 0;
  int n_fail = 0;
  int lat;
  logic ph_hold;

  ledr_channel_receiver #(
    .WIDTH      (W),
    .SYNC_STAGES(SS)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ledr_d    (src_d),
    .ledr_r    (src_r),
    .ledr_a    (ledr_a),
    .word      (word),
    .word_valid(word_valid),
    .word_ready(word_ready),
    .bit_count (bit_count),
    .proto_err (proto_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    @(negedge clk);
    if (b != src_d) src_d = ~src_d;
    else            src_r = ~src_r;
  endtask

  task automatic wait_ack(input string tag, output int cyc);
    logic ph;
    ph  = src_d ^ src_r;
    cyc = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (ledr_a === ph) begin
        cyc = i;
        break;
      end
    end
    if (cyc == 0) check({tag, "_ack_timeout"}, {31'd0, ledr_a}, {31'd0, ph});
  endtask

  task automatic send_bit(input logic b, input string tag, output int cyc);
    drive_bit(b);
    wait_ack(tag, cyc);
  endtask

  task automatic send_bits(input logic [7:0] w, input int lo, input int hi,
                           input string tag);
    int c;
    for (int i = lo; i <= hi; i++) send_bit(w[i], tag, c);
  endtask

  task automatic send_word(input logic [7:0] w, input string tag);
    send_bits(w, 0, 7, tag);
    check({tag, "_word"}, {24'd0, word}, {24'd0, w});
    check({tag, "_valid"}, {31'd0, word_valid}, 32'd1);
  endtask

  initial begin
    rst_n      = 1'b0;
    src_d      = 1'b0;
    src_r      = 1'b0;
    word_ready = 1'b1;

    // T1 reset state
    tick(3);
    check("t1_ack", {31'd0, ledr_a}, 32'd0);
    check("t1_valid", {31'd0, word_valid}, 32'd0);
    check("t1_count", {28'd0, bit_count}, 32'd0);
    check("t1_err", {31'd0, proto_err}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(4);

    // T2 word 0xA5 = bits 1,0,1,0,0,1,0,1
    send_bit(1'b1, "t2", lat);
    check("t2_first_lat", lat, SS + 1);
    send_bits(8'hA5, 1, 2, "t2");
    check("t2_count3", {28'd0, bit_count}, 32'd3);
    send_bits(8'hA5, 3, 7, "t2");
    check("t2_word", {24'd0, word}, 32'hA5);
    check("t2_valid", {31'd0, word_valid}, 32'd1);
    check("t2_ack_end", {31'd0, ledr_a}, 32'd0);
    check("t2_count0", {28'd0, bit_count}, 32'd0);
    tick(1);
    check("t2_valid_1clk", {31'd0, word_valid}, 32'd0);
    check("t2_word_hold", {24'd0, word}, 32'hA5);

    // T3 runs of equal bits travel on r
    send_word(8'h00, "t3a");
    tick(1);
    check("t3a_drain", {31'd0, word_valid}, 32'd0);
    send_word(8'hFF, "t3b");
    tick(1);
    check("t3b_drain", {31'd0, word_valid}, 32'd0);

    // T4 backpressure
    word_ready = 1'b0;
    send_word(8'h3C, "t4a");
    send_bits(8'hC3, 0, 6, "t4b");
    check("t4_count7", {28'd0, bit_count}, 32'd7);
    ph_hold = ledr_a;
    drive_bit(1'b1);
    tick(10);
    check("t4_ack_held", {31'd0, ledr_a}, {31'd0, ph_hold});
    check("t4_word_held", {24'd0, word}, 32'h3C);
    check("t4_valid_held", {31'd0, word_valid}, 32'd1);
    check("t4_count_held", {28'd0, bit_count}, 32'd7);
    @(negedge clk);
    word_ready = 1'b1;
    tick(1);
    check("t4_ack_go", {31'd0, ledr_a}, {31'd0, src_d ^ src_r});
    check("t4_word2", {24'd0, word}, 32'hC3);
    check("t4_valid2", {31'd0, word_valid}, 32'd1);
    check("t4_count0", {28'd0, bit_count}, 32'd0);
    tick(1);
    check("t4_drain", {31'd0, word_valid}, 32'd0);

    // T5 double toggle mid-word, 0x5A = bits 0,1,0,1,1,0,1,0
    send_bits(8'h5A, 0, 1, "t5a");
    check("t5_err_pre", {31'd0, proto_err}, 32'd0);
    ph_hold = ledr_a;
    @(negedge clk);
    src_d = ~src_d;
    src_r = ~src_r;
    tick(6);
    check("t5_err", {31'd0, proto_err}, 32'd1);
    check("t5_ack_same", {31'd0, ledr_a}, {31'd0, ph_hold});
    check("t5_count_same", {28'd0, bit_count}, 32'd2);
    send_bits(8'h5A, 2, 7, "t5b");
    check("t5_word", {24'd0, word}, 32'h5A);
    check("t5_valid", {31'd0, word_valid}, 32'd1);
    check("t5_err_sticky", {31'd0, proto_err}, 32'd1);
    tick(1);

    // T6 reset mid-word, then 0x81
    send_bits(8'h81, 0, 2, "t6a");
    check("t6_count3", {28'd0, bit_count}, 32'd3);
    @(negedge clk);
    rst_n = 1'b0;
    src_d = 1'b0;
    src_r = 1'b0;
    tick(2);
    check("t6_rst_count", {28'd0, bit_count}, 32'd0);
    check("t6_rst_ack", {31'd0, ledr_a}, 32'd0);
    check("t6_rst_err", {31'd0, proto_err}, 32'd0);
    check("t6_rst_valid", {31'd0, word_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(4);
    check("t6_idle_ack", {31'd0, ledr_a}, 32'd0);
    send_word(8'h81, "t6b");
    check("t6_ack_end", {31'd0, ledr_a}, 32'd0);
    tick(1);
    check("t6_drain", {31'd0, word_valid}, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
